// File: rtl/avmm_host_cmd_arbiter.sv
// Two-requester (read/write) command arbiter toward the CCI-P host bridge, with read credits and write-burst lock.
// Optional build macro CMD_ARB_RD_PRIORITY_EN selects fixed read priority instead of round-robin.
module avmm_host_cmd_arbiter #(
  parameter int CMD_WIDTH      = 564,
  parameter int BURST_WIDTH    = 3,
  parameter int MAX_RD_CREDITS = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CMD_WIDTH-1:0]              rd_cmd_data,
  input  logic                              rd_cmd_valid,
  output logic                              rd_cmd_ready,
  input  logic [CMD_WIDTH-1:0]              wr_cmd_data,
  input  logic                              wr_cmd_valid,
  output logic                              wr_cmd_ready,
  output logic [CMD_WIDTH-1:0]              out_cmd_data,
  output logic                              out_cmd_valid,
  input  logic                              out_cmd_ready,
  input  logic                              rd_rsp_beat,
  output logic [$clog2(MAX_RD_CREDITS):0]   rd_credits,
  output logic                              credit_err
);

  localparam int CW = $clog2(MAX_RD_CREDITS) + 1;
  localparam int EW = CW + 3;

  localparam logic [0:0] ST_ARB     = 1'b0;
  localparam logic [0:0] ST_WR_LOCK = 1'b1;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  // Only bursts of 1, 2 and 4 are legal; anything else is serviced as a single beat.
  function automatic logic [2:0] decode_burst(input logic [BURST_WIDTH-1:0] field);
    if (field == BURST_WIDTH'(2)) return 3'd2;
    else if (field == BURST_WIDTH'(4)) return 3'd4;
    return 3'd1;
  endfunction

  logic [0:0]    state;
  logic [2:0]    beat_cnt;
  logic          last_grant;
  logic          hold_q;
  logic          held_grant;

  logic [2:0]    rd_burst;
  logic [2:0]    wr_burst;
  logic          rd_elig;
  logic          wr_elig;
  logic          grant_any;
  logic          grant_wr;
  logic          rd_accept;
  logic          wr_accept;
  logic [2:0]    consume;
  logic [EW-1:0] credit_sum;
  logic          credit_ovf;

  assign rd_burst = decode_burst(rd_cmd_data[BURST_WIDTH:1]);
  assign wr_burst = decode_burst(wr_cmd_data[BURST_WIDTH:1]);
  assign rd_elig  = rd_cmd_valid && (EW'(rd_credits) >= EW'(rd_burst));
  assign wr_elig  = wr_cmd_valid;

  // Grant selection: burst lock first, then a grant stalled by backpressure, then arbitration.
  always_comb begin
    grant_any = 1'b0;
    grant_wr  = GRANT_WR;
    if (state == ST_WR_LOCK) begin
      grant_any = wr_elig;
      grant_wr  = GRANT_WR;
    end else if (hold_q && ((held_grant == GRANT_WR) ? wr_elig : rd_elig)) begin
      grant_any = 1'b1;
      grant_wr  = held_grant;
    end else if (rd_elig && wr_elig) begin
      grant_any = 1'b1;
`ifdef CMD_ARB_RD_PRIORITY_EN
      grant_wr  = GRANT_RD;
`else
      grant_wr  = (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
`endif
    end else if (rd_elig) begin
      grant_any = 1'b1;
      grant_wr  = GRANT_RD;
    end else if (wr_elig) begin
      grant_any = 1'b1;
      grant_wr  = GRANT_WR;
    end
  end

  assign out_cmd_valid = grant_any && !reset;
  assign out_cmd_data  = !grant_any ? '0 : (grant_wr ? wr_cmd_data : rd_cmd_data);
  assign rd_cmd_ready  = out_cmd_valid && (grant_wr == GRANT_RD) && out_cmd_ready;
  assign wr_cmd_ready  = out_cmd_valid && (grant_wr == GRANT_WR) && out_cmd_ready;
  assign rd_accept     = rd_cmd_ready;
  assign wr_accept     = wr_cmd_ready;

  assign consume    = rd_accept ? rd_burst : 3'd0;
  assign credit_sum = EW'(rd_credits) + EW'(rd_rsp_beat) - EW'(consume);
  assign credit_ovf = credit_sum > EW'(MAX_RD_CREDITS);

  // Burst tracking and round-robin history; a write burst is only credited as served at its last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ARB;
      beat_cnt   <= 3'd0;
      last_grant <= GRANT_WR;
    end else begin
      case (state)
        ST_ARB: begin
          if (wr_accept) begin
            if (wr_burst != 3'd1) begin
              state    <= ST_WR_LOCK;
              beat_cnt <= wr_burst - 3'd1;
            end else begin
              last_grant <= GRANT_WR;
            end
          end else if (rd_accept) begin
            last_grant <= GRANT_RD;
          end
        end
        ST_WR_LOCK: begin
          if (wr_accept) begin
            if (beat_cnt == 3'd1) begin
              state      <= ST_ARB;
              beat_cnt   <= 3'd0;
              last_grant <= GRANT_WR;
            end else begin
              beat_cnt <= beat_cnt - 3'd1;
            end
          end
        end
        default: begin
          state    <= ST_ARB;
          beat_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Credits saturate at the maximum; a return that would exceed it latches the error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_credits <= CW'(MAX_RD_CREDITS);
      credit_err <= 1'b0;
    end else if (credit_ovf) begin
      rd_credits <= CW'(MAX_RD_CREDITS);
      credit_err <= 1'b1;
    end else begin
      rd_credits <= credit_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= 1'b0;
      held_grant <= GRANT_WR;
    end else begin
      hold_q     <= out_cmd_valid && !out_cmd_ready;
      held_grant <= grant_wr;
    end
  end

endmodule
